inst_fetch_resp: RTL and testbench

Instruction-fetch responder for the dual-issue front end. Takes the fetch PC held in the PC register, issues one 64-bit aligned read on the SRAM-like instruction bus, and returns up to two instructions. It also produces the `inst_rdata_1_ok` / `inst_rdata_2_ok` pair that the next-PC logic uses to advance the PC by 0, 4 or 8. Redirects (branch, jump, jr, exception) flush any in-flight fetch so stale instructions are never delivered.

---
 rtl/inst_fetch_resp.sv | 118 +++++++++++
 tb/tb_inst_fetch_resp.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: one 64-bit aligned read per fetch, delivers up to two
// instructions and the slot-ok pair used by next-PC logic; redirects kill in-flight fetches.
`timescale 1ns/1ps
module inst_fetch_resp (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    input  logic        flush,
    input  logic        out_ready,
    output logic        inst_rdata_1_ok,
    output logic        inst_rdata_2_ok,
    output logic [31:0] inst_rdata_1,
    output logic [31:0] inst_rdata_2,
    output logic [31:0] inst_pc_1,
    output logic        inst_adel,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [63:0] inst_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state;
    logic        discard;
    logic        two_slot;
    logic [31:0] req_pc;
    logic        pc_aligned;

    assign pc_aligned = (pc[1:0] == 2'b00);

    always_comb begin
        inst_req        = (state == REQ) && pc_aligned;
        inst_addr       = (state == REQ) ? {pc[31:3], 3'b000} : '0;
        inst_rdata_1_ok = (state == HOLD) && out_ready && !flush;
        inst_rdata_2_ok = inst_rdata_1_ok && two_slot;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            discard      <= 1'b0;
            two_slot     <= 1'b0;
            req_pc       <= '0;
            inst_rdata_1 <= '0;
            inst_rdata_2 <= '0;
            inst_pc_1    <= '0;
            inst_adel    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pc_valid && !flush)
                        state <= REQ;
                end
                REQ: begin
                    if (!pc_aligned) begin
                        // a redirect makes the address error stale, so it is not reported
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            state        <= HOLD;
                            inst_adel    <= 1'b1;
                            inst_rdata_1 <= '0;
                            inst_rdata_2 <= '0;
                            inst_pc_1    <= pc;
                            two_slot     <= 1'b0;
                        end
                    end else if (inst_addr_ok) begin
                        req_pc  <= pc;
                        discard <= flush;
                        state   <= WAIT;
                    end else if (flush) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        discard <= 1'b0;
                        if (discard || flush) begin
                            state <= IDLE;
                        end else begin
                            state     <= HOLD;
                            inst_adel <= 1'b0;
                            inst_pc_1 <= req_pc;
                            if (!req_pc[2]) begin
                                inst_rdata_1 <= inst_rdata[31:0];
                                inst_rdata_2 <= inst_rdata[63:32];
                                two_slot     <= 1'b1;
                            end else begin
                                inst_rdata_1 <= inst_rdata[63:32];
                                inst_rdata_2 <= '0;
                                two_slot     <= 1'b0;
                            end
                        end
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        state        <= IDLE;
                        inst_rdata_1 <= '0;
                        inst_rdata_2 <= '0;
                        inst_pc_1    <= '0;
                        inst_adel    <= 1'b0;
                        two_slot     <= 1'b0;
                    end else if (inst_rdata_1_ok) begin
                        state <= pc_valid ? REQ : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Scoreboard bench for inst_fetch_resp: directed fetches push expected groups,
// a monitor pops and compares on every delivery; a small bus model answers requests.
`timescale 1ns/1ps
module tb_inst_fetch_resp;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] pc;
    logic        pc_valid, flush, out_ready;
    logic        inst_rdata_1_ok, inst_rdata_2_ok;
    logic [31:0] inst_rdata_1, inst_rdata_2, inst_pc_1;
    logic        inst_adel, inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [63:0] inst_rdata;

    inst_fetch_resp dut (
        .clk(clk), .resetn(resetn), .pc(pc), .pc_valid(pc_valid), .flush(flush),
        .out_ready(out_ready), .inst_rdata_1_ok(inst_rdata_1_ok),
        .inst_rdata_2_ok(inst_rdata_2_ok), .inst_rdata_1(inst_rdata_1),
        .inst_rdata_2(inst_rdata_2), .inst_pc_1(inst_pc_1), .inst_adel(inst_adel),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ok2;
        logic [31:0] i1;
        logic [31:0] i2;
        logic [31:0] pc1;
        logic        adel;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   delivered = 0;
    int   accepts = 0;

    // bus model knobs
    logic        addr_ok_en = 1'b1;
    logic [63:0] bus_data = '0;
    int unsigned data_delay = 0;
    logic        pend = 1'b0;
    int unsigned cnt = 0;
    logic [63:0] pend_data = '0;

    assign inst_addr_ok = addr_ok_en & inst_req;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic ok2, input logic [31:0] i1, input logic [31:0] i2,
                            input logic [31:0] pc1, input logic adel);
        exp_t e;
        e.ok2 = ok2; e.i1 = i1; e.i2 = i2; e.pc1 = pc1; e.adel = adel;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_deliv(input string name, input int target, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (delivered >= target) break;
            cyc();
        end
        chk(name, 64'(delivered), 64'(target));
    endtask

    // zero-wait-capable bus responder; data_ok comes data_delay cycles after acceptance
    initial begin
        logic acc;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        forever begin
            @(negedge clk);
            acc = inst_req && inst_addr_ok && resetn;
            if (acc) accepts = accepts + 1;
            @(posedge clk);
            #1;
            inst_data_ok = 1'b0;
            inst_rdata   = {$urandom, $urandom};
            if (!resetn) pend = 1'b0;
            if (acc) begin
                pend      = 1'b1;
                cnt       = data_delay;
                pend_data = bus_data;
            end
            if (pend) begin
                if (cnt == 0) begin
                    inst_data_ok = 1'b1;
                    inst_rdata   = pend_data;
                    pend         = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
        end
    end

    // monitor: every delivery must match the oldest expected group
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && inst_rdata_2_ok && !inst_rdata_1_ok)
                chk("ok2_without_ok1", 64'(inst_rdata_2_ok), 64'd0);
            if (resetn && inst_rdata_1_ok) begin
                delivered = delivered + 1;
                if (sb.size() == 0) begin
                    chk("unexpected_delivery_pc", 64'(inst_pc_1), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("deliv_ok2",  64'(inst_rdata_2_ok), 64'(e.ok2));
                    chk("deliv_i1",   64'(inst_rdata_1),    64'(e.i1));
                    chk("deliv_i2",   64'(inst_rdata_2),    64'(e.i2));
                    chk("deliv_pc1",  64'(inst_pc_1),       64'(e.pc1));
                    chk("deliv_adel", 64'(inst_adel),       64'(e.adel));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int d0;
        int a0;
        resetn = 1'b0; pc = '0; pc_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("rst_ok",   {62'd0, inst_rdata_1_ok, inst_rdata_2_ok}, 64'd0);
        chk("rst_req",  64'(inst_req), 64'd0);
        chk("rst_addr", 64'(inst_addr), 64'd0);
        chk("rst_data", {inst_rdata_2, inst_rdata_1}, 64'd0);
        chk("rst_pc1",  {31'd0, inst_adel, inst_pc_1}, 64'd0);
        cyc();
        cyc();
        resetn = 1'b1;
        cyc();

        // aligned two-wide fetch, best-case latency
        pc = 32'hBFC0_0000; pc_valid = 1'b1; out_ready = 1'b1;
        bus_data = 64'h2402_0002_2401_0001; data_delay = 0;
        push_exp(1'b1, 32'h2401_0001, 32'h2402_0002, 32'hBFC0_0000, 1'b0);
        @(negedge clk);
        chk("t1_idle_req", 64'(inst_req), 64'd0);
        cyc();
        pc_valid = 1'b0;
        @(negedge clk);
        chk("t1_req",  64'(inst_req), 64'd1);
        chk("t1_addr", 64'(inst_addr), 64'hBFC0_0000);
        cyc();
        cyc();
        @(negedge clk);
        chk("t1_cycle3_ok", {62'd0, inst_rdata_1_ok, inst_rdata_2_ok}, 64'd3);
        cyc();
        cyc();

        // odd-word fetch: only the upper word, single slot
        pc = 32'hBFC0_0004; pc_valid = 1'b1;
        bus_data = 64'h1111_1111_2222_2222;
        push_exp(1'b0, 32'h1111_1111, 32'h0, 32'hBFC0_0004, 1'b0);
        cyc();
        pc_valid = 1'b0;
        @(negedge clk);
        chk("t2_addr", 64'(inst_addr), 64'hBFC0_0000);
        d0 = delivered + 1;
        wait_deliv("t2_deliv", d0, 10);
        cyc();

        // backpressure: HOLD keeps the captured data while the bus toggles
        pc = 32'hBFC0_0008; pc_valid = 1'b1; out_ready = 1'b0;
        bus_data = 64'hAAAA_0002_AAAA_0001;
        push_exp(1'b1, 32'hAAAA_0001, 32'hAAAA_0002, 32'hBFC0_0008, 1'b0);
        d0 = delivered;
        cyc();
        pc_valid = 1'b0;
        cyc();
        cyc();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_bp_ok",  {62'd0, inst_rdata_1_ok, inst_rdata_2_ok}, 64'd0);
            chk("t3_bp_buf", {inst_rdata_2, inst_rdata_1}, 64'hAAAA_0002_AAAA_0001);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("t3_once", 64'(delivered - d0), 64'd1);

        // flush one cycle after addr_ok, data three cycles later
        pc = 32'hBFC0_0010; pc_valid = 1'b1; bus_data = 64'hDEAD_0002_DEAD_0001; data_delay = 3;
        d0 = delivered;
        cyc();
        pc_valid = 1'b0;
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        chk("t4_no_deliv", 64'(delivered), 64'(d0));
        chk("t4_idle_req", 64'(inst_req), 64'd0);
        cyc();
        pc = 32'hBFC0_0100; pc_valid = 1'b1; bus_data = 64'h0000_000C_0000_000B; data_delay = 0;
        push_exp(1'b1, 32'h0000_000B, 32'h0000_000C, 32'hBFC0_0100, 1'b0);
        cyc();
        pc_valid = 1'b0;
        wait_deliv("t4_redirect", d0 + 1, 10);
        cyc();

        // flush coincident with addr_ok, then with data_ok
        d0 = delivered;
        pc = 32'hBFC0_0200; pc_valid = 1'b1; bus_data = 64'hBAD0_0002_BAD0_0001;
        cyc();
        pc_valid = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0;
        repeat (3) cyc();
        pc = 32'hBFC0_0300; pc_valid = 1'b1; bus_data = 64'hBAD1_0002_BAD1_0001;
        cyc();
        pc_valid = 1'b0;
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        repeat (4) cyc();
        chk("t5_no_deliv", 64'(delivered), 64'(d0));

        // misaligned pc: address error without a bus request
        a0 = accepts;
        pc = 32'hBFC0_0002; pc_valid = 1'b1;
        push_exp(1'b0, 32'h0, 32'h0, 32'hBFC0_0002, 1'b1);
        cyc();
        pc_valid = 1'b0;
        @(negedge clk);
        chk("t6_no_req", 64'(inst_req), 64'd0);
        chk("t6_addr",   64'(inst_addr), 64'hBFC0_0000);
        cyc();
        @(negedge clk);
        chk("t6_adel", {61'd0, inst_rdata_1_ok, inst_rdata_2_ok, inst_adel}, 64'd5);
        cyc();
        cyc();
        chk("t6_no_accept", 64'(accepts), 64'(a0));

        // reset in WAIT: every output drops at once
        pc = 32'hBFC0_0020; pc_valid = 1'b1; bus_data = 64'h5555_0002_5555_0001; data_delay = 5;
        cyc();
        pc_valid = 1'b0;
        cyc();
        cyc();
        resetn = 1'b0;
        #1;
        chk("t7_rst_pc1",  64'(inst_pc_1), 64'd0);
        chk("t7_rst_adel", 64'(inst_adel), 64'd0);
        chk("t7_rst_bus",  {31'd0, inst_req, inst_addr}, 64'd0);
        chk("t7_rst_ok",   {62'd0, inst_rdata_1_ok, inst_rdata_2_ok}, 64'd0);
        chk("t7_rst_data", {inst_rdata_2, inst_rdata_1}, 64'd0);
        cyc();
        cyc();
        resetn = 1'b1;
        cyc();
        d0 = delivered;
        pc = 32'hBFC0_0040; pc_valid = 1'b1; bus_data = 64'h7777_0002_7777_0001; data_delay = 0;
        push_exp(1'b1, 32'h7777_0001, 32'h7777_0002, 32'hBFC0_0040, 1'b0);
        cyc();
        pc_valid = 1'b0;
        wait_deliv("t7_recover", d0 + 1, 10);
        repeat (3) cyc();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
